// File: rtl/uart_cmd_decoder.sv
// UART command decoder: buffers received bytes in a small FIFO, turns single ASCII
// letters into one-cycle control pulses and optionally acknowledges each one over the UART TX.
module uart_cmd_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ECHO_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       cmd_run,
  output logic       cmd_clear,
  output logic       cmd_mode,
  output logic       cmd_hour,
  output logic       cmd_min,
  output logic       cmd_sec,
  output logic       overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_START, S_WAIT} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  state_e     state_q;
  logic [7:0] cur_byte_q;
  logic [5:0] cmd_q;
  logic [7:0] tx_data_q;

  logic [7:0] head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // Clearing bit 5 folds lowercase ASCII letters onto uppercase; order is {run,clear,mode,hour,min,sec}.
  function automatic logic [5:0] decode_cmd(input logic [7:0] b);
    logic [5:0] cmd;
    cmd = '0;
    case (b & 8'hDF)
      8'h52:   cmd = 6'b100000;
      8'h43:   cmd = 6'b010000;
      8'h4D:   cmd = 6'b001000;
      8'h48:   cmd = 6'b000100;
      8'h4E:   cmd = 6'b000010;
      8'h53:   cmd = 6'b000001;
      default: cmd = '0;
    endcase
    return cmd;
  endfunction

  assign head       = mem_q[rd_ptr_q];
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push       = rx_done && (!fifo_full || pop);
  assign overflow   = rx_done && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // Command pulses are registered at the pop edge so they are high exactly during DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_byte_q <= 8'h00;
      cmd_q      <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      cmd_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_byte_q <= head;
            cmd_q      <= decode_cmd(head);
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cur_byte_q == 8'h0D || cur_byte_q == 8'h0A || ECHO_EN == 0) begin
            state_q <= S_IDLE;
          end else begin
            tx_data_q <= (cmd_q != '0) ? (cur_byte_q & 8'hDF) : 8'h3F;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (!tx_busy) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // tx_start follows tx_busy directly so it can never coincide with a busy transmitter.
  assign tx_start  = (state_q == S_START) && !tx_busy;
  assign tx_data   = tx_data_q;
  assign cmd_run   = cmd_q[5];
  assign cmd_clear = cmd_q[4];
  assign cmd_mode  = cmd_q[3];
  assign cmd_hour  = cmd_q[2];
  assign cmd_min   = cmd_q[1];
  assign cmd_sec   = cmd_q[0];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: one echoing and one silent instance share the RX stream and are
// checked against a byte-level model of the command set and acknowledge bytes.
module tb_uart_cmd_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDone;
  logic       holdBusy;
  logic       respBusy;
  logic       txDone;
  logic       txBusy;

  logic       txStart, overflow, cmdRun, cmdClear, cmdMode, cmdHour, cmdMin, cmdSec;
  logic [7:0] txData;
  logic       txStart0, overflow0, cmdRun0, cmdClear0, cmdMode0, cmdHour0, cmdMin0, cmdSec0;
  logic [7:0] txData0;
  logic [5:0] cmdVec, cmdVec0;

  always #5 clk = ~clk;

  assign txBusy  = holdBusy | respBusy;
  assign cmdVec  = {cmdRun, cmdClear, cmdMode, cmdHour, cmdMin, cmdSec};
  assign cmdVec0 = {cmdRun0, cmdClear0, cmdMode0, cmdHour0, cmdMin0, cmdSec0};

  uart_cmd_decoder #(.FIFO_DEPTH(DEPTH), .ECHO_EN(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rxData), .rx_done(rxDone),
    .tx_busy(txBusy), .tx_done(txDone), .tx_start(txStart), .tx_data(txData),
    .cmd_run(cmdRun), .cmd_clear(cmdClear), .cmd_mode(cmdMode), .cmd_hour(cmdHour),
    .cmd_min(cmdMin), .cmd_sec(cmdSec), .overflow(overflow)
  );

  uart_cmd_decoder #(.FIFO_DEPTH(DEPTH), .ECHO_EN(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rxData), .rx_done(rxDone),
    .tx_busy(txBusy), .tx_done(txDone), .tx_start(txStart0), .tx_data(txData0),
    .cmd_run(cmdRun0), .cmd_clear(cmdClear0), .cmd_mode(cmdMode0), .cmd_hour(cmdHour0),
    .cmd_min(cmdMin0), .cmd_sec(cmdSec0), .overflow(overflow0)
  );

  int checks = 0;
  int errors = 0;

  logic [5:0] expCmdQ[$];
  logic [5:0] expCmd0Q[$];
  logic [7:0] expTxQ[$];
  int sentCount = 0, doneCount = 0, tx0Count = 0, txStartCount = 0;
  int cmdEvents = 0, ovfSeen = 0, ovfExpected = 0;
  int respDelayMin = 1, respDelayMax = 4;
  bit awaitingDone = 0;
  logic [7:0] latchedTx = 8'h00;
  logic [7:0] letters [12] = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h6D, 8'h4D,
                               8'h68, 8'h48, 8'h6E, 8'h4E, 8'h73, 8'h53};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: uppercase the letter arithmetically, then look it up in the command set.
  function automatic logic [7:0] modelUpper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
  endfunction

  function automatic logic [5:0] modelCmd(input logic [7:0] b);
    logic [7:0] up;
    up = modelUpper(b);
    if (up == "R") return 6'b100000;
    if (up == "C") return 6'b010000;
    if (up == "M") return 6'b001000;
    if (up == "H") return 6'b000100;
    if (up == "N") return 6'b000010;
    if (up == "S") return 6'b000001;
    return 6'b000000;
  endfunction

  function automatic bit modelHasResp(input logic [7:0] b);
    return !(b == 8'h0D || b == 8'h0A);
  endfunction

  function automatic logic [7:0] modelResp(input logic [7:0] b);
    return (modelCmd(b) != 0) ? modelUpper(b) : 8'h3F;
  endfunction

  // Called at posedge+1; leaves at the next posedge+1 so calls can run back to back.
  task automatic applyStimulus(input logic [7:0] b, input bit expOvf, input bit recEcho, input bit recNoEcho);
    rxData = b;
    rxDone = 1'b1;
    @(negedge clk);
    checkOutput("overflow", overflow, expOvf);
    checkOutput("overflow0", overflow0, 0);
    if (expOvf) ovfExpected++;
    if (recEcho && !expOvf) begin
      if (modelCmd(b) != 0) expCmdQ.push_back(modelCmd(b));
      if (modelHasResp(b)) begin
        expTxQ.push_back(modelResp(b));
        sentCount++;
      end
    end
    if (recNoEcho && modelCmd(b) != 0) expCmd0Q.push_back(modelCmd(b));
    @(posedge clk);
    #1 rxDone = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((expCmdQ.size() != 0 || expCmd0Q.size() != 0 || expTxQ.size() != 0 ||
            sentCount != doneCount) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) checkOutput("drainTimeout", n, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Transmitter model: goes busy after tx_start and reports tx_done after a random delay.
  initial begin
    respBusy = 1'b0;
    txDone   = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart && !rst) begin
        @(posedge clk);
        #1 respBusy = 1'b1;
        repeat ($urandom_range(respDelayMax, respDelayMin)) @(posedge clk);
        #1 txDone = 1'b1;
        @(posedge clk);
        #1 txDone = 1'b0;
        respBusy = 1'b0;
      end
    end
  end

  // Monitor: every pulse and every transmit is matched against the model queues.
  initial begin
    logic [31:0] expVal;
    forever begin
      @(negedge clk);
      if (rst) begin
        awaitingDone = 0;
      end else begin
        if (cmdVec != 0) begin
          cmdEvents++;
          expVal = (expCmdQ.size() > 0) ? 32'(expCmdQ.pop_front()) : 32'hBAD;
          checkOutput("cmdPulse", cmdVec, expVal);
        end
        if (cmdVec0 != 0) begin
          expVal = (expCmd0Q.size() > 0) ? 32'(expCmd0Q.pop_front()) : 32'hBAD;
          checkOutput("cmdPulse0", cmdVec0, expVal);
        end
        if (txStart) begin
          txStartCount++;
          checkOutput("startWhileBusy", txBusy, 0);
          checkOutput("startTwice", awaitingDone, 0);
          expVal = (expTxQ.size() > 0) ? 32'(expTxQ.pop_front()) : 32'hBAD;
          checkOutput("txData", txData, expVal);
          awaitingDone = 1;
          latchedTx = txData;
        end else if (awaitingDone && txData != latchedTx) begin
          checkOutput("txStable", txData, latchedTx);
        end
        if (txDone && awaitingDone) begin
          awaitingDone = 0;
          doneCount++;
        end
        if (txStart0) tx0Count++;
        if (overflow) ovfSeen++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int evBefore, startBefore, r;
    logic [7:0] b;
    rst = 1'b1;
    rxData = 8'h00;
    rxDone = 1'b0;
    holdBusy = 1'b0;
    #12;
    checkOutput("rstTxStart", txStart, 0);
    checkOutput("rstTxData", txData, 8'h00);
    checkOutput("rstCmd", cmdVec, 0);
    checkOutput("rstOverflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single 'r': pulse in the cycle after the pop, acknowledge right after.
    applyStimulus(8'h72, 0, 1, 1);
    @(negedge clk);
    checkOutput("runEarly", cmdRun, 0);
    @(negedge clk);
    checkOutput("runPulse", cmdRun, 1);
    checkOutput("run0Pulse", cmdRun0, 1);
    checkOutput("startDuringDecode", txStart, 0);
    @(negedge clk);
    checkOutput("runFall", cmdRun, 0);
    checkOutput("startAfterDecode", txStart, 1);
    checkOutput("ackR", txData, 8'h52);
    @(posedge clk);
    #1;
    waitDrain(200);

    // Back-to-back commands while the transmitter is held busy.
    holdBusy = 1'b1;
    applyStimulus("C", 0, 1, 1);
    applyStimulus("n", 0, 1, 1);
    applyStimulus("S", 0, 1, 1);
    repeat (6) @(posedge clk);
    #1 holdBusy = 1'b0;
    waitDrain(300);

    // Unknown byte answers '?', carriage return is silent.
    applyStimulus("z", 0, 1, 1);
    waitDrain(200);
    evBefore = cmdEvents;
    startBefore = txStartCount;
    applyStimulus(8'h0D, 0, 1, 1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("crNoPulse", cmdEvents, evBefore);
    checkOutput("crNoStart", txStartCount, startBefore);

    // Fill the FIFO while the FSM is parked in START; the fifth byte is dropped.
    holdBusy = 1'b1;
    applyStimulus("r", 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus("M", 0, 1, 1);
    applyStimulus("h", 0, 1, 1);
    applyStimulus("?", 0, 1, 1);
    applyStimulus("s", 0, 1, 1);
    applyStimulus("c", 1, 1, 1);
    @(negedge clk);
    checkOutput("ovfOneCycle", overflow, 0);
    @(posedge clk);
    #1 holdBusy = 1'b0;
    waitDrain(400);

    // Silent instance: one DECODE per byte, back to back.
    applyStimulus("m", 0, 1, 1);
    applyStimulus("h", 0, 1, 1);
    @(negedge clk);
    checkOutput("mode0Pulse", cmdVec0, 6'b001000);
    @(negedge clk);
    checkOutput("gap0", cmdVec0, 0);
    @(negedge clk);
    checkOutput("hour0Pulse", cmdVec0, 6'b000100);
    @(posedge clk);
    #1;
    waitDrain(300);

    // Reset while waiting for tx_done with two bytes queued.
    respDelayMin = 30;
    respDelayMax = 30;
    applyStimulus("r", 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus("c", 0, 0, 1);
    applyStimulus("h", 0, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("waitBeforeRst", awaitingDone, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidTxStart", txStart, 0);
    checkOutput("rstMidCmd", cmdVec, 0);
    checkOutput("rstMidTxData", txData, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    doneCount = sentCount;
    evBefore = cmdEvents;
    startBefore = txStartCount;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("fifoEmptyAfterRst", cmdEvents, evBefore);
    checkOutput("noStartAfterRst", txStartCount, startBefore);
    respDelayMin = 1;
    respDelayMax = 4;
    applyStimulus("r", 0, 1, 1);
    waitDrain(200);

    // Random traffic, throttled so the echoing FIFO never fills.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) b = letters[$urandom_range(0, 11)];
      else if (r == 6) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      else b = 8'($urandom_range(0, 255));
      if (!modelHasResp(b)) begin
        waitDrain(300);
        applyStimulus(b, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
      end else begin
        for (int w = 0; w < 300 && (sentCount - doneCount) >= DEPTH; w++) begin
          @(posedge clk);
          #1;
        end
        applyStimulus(b, 0, 1, 1);
      end
      if ($urandom_range(0, 15) == 0) begin
        holdBusy = 1'b1;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1 holdBusy = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    waitDrain(1000);

    checkOutput("cmdQueueEmpty", expCmdQ.size(), 0);
    checkOutput("cmd0QueueEmpty", expCmd0Q.size(), 0);
    checkOutput("txQueueEmpty", expTxQ.size(), 0);
    checkOutput("silentNoTx", tx0Count, 0);
    checkOutput("overflowTotal", ovfSeen, ovfExpected);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Downstream consumer of the UART receiver in the dual-watch design. Buffers received bytes in a small FIFO and decodes single-character ASCII commands into one-cycle control pulses for the stopwatch/watch cores. Returns an acknowledge byte through the UART transmitter's tx_start/tx_data handshake.

Parameters:
FIFO_DEPTH, 4, number of entries in the rx byte FIFO (power of two, ≥2)
ECHO_EN, 1, 1 = send an acknowledge/error byte per decoded command; 0 = no tx traffic

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle pulse, byte received
tx_busy  input  1  transmitter busy
tx_done  input  1  one-cycle pulse, transmit finished
tx_start  output  1  one-cycle pulse, start transmit
tx_data  output  8  byte to transmit, stable from tx_start until tx_done
cmd_run  output  1  pulse: run/stop toggle
cmd_clear  output  1  pulse: clear
cmd_mode  output  1  pulse: stopwatch/watch mode toggle
cmd_hour  output  1  pulse: hour increment
cmd_min  output  1  pulse: minute increment
cmd_sec  output  1  pulse: second increment
overflow  output  1  one-cycle pulse, byte dropped because FIFO full

Behaviour:
- Reset: clk and rst as named; reset is asynchronous, active-high. All outputs 0, tx_data=8'h00, FIFO empty, FSM=IDLE. Reset mid-transmit aborts the transaction; the pending byte is discarded.
- FIFO push: when rx_done=1 and the FIFO is not full, rx_data is written at that edge.
- FIFO full: when rx_done=1 and the FIFO is full with no pop in the same cycle, the byte is dropped and overflow=1 for exactly that cycle.
- Simultaneous push and pop: both take effect and the count is unchanged. This applies when full, so no overflow is raised.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into cur_byte and go to DECODE.
  - DECODE (one cycle): case-insensitive match on cur_byte.
    - 'r'/'R' → cmd_run
    - 'c'/'C' → cmd_clear
    - 'm'/'M' → cmd_mode
    - 'h'/'H' → cmd_hour
    - 'n'/'N' → cmd_min
    - 's'/'S' → cmd_sec
    - The matching pulse is high during this cycle only; all other cmd_* stay 0.
    - Valid command: resp = uppercase letter.
    - 0x0D or 0x0A: no pulse, no response, go to IDLE.
    - Any other byte: no pulse, resp = 0x3F ('?').
    - If ECHO_EN=0: go to IDLE. Otherwise load tx_data=resp and go to START.
  - START: when tx_busy=0, drive tx_start=1 for one cycle and go to WAIT. While tx_busy=1, hold in START with tx_start=0.
  - WAIT: on tx_done=1 go to IDLE. tx_data stays stable throughout.
- Latency (idle, FIFO empty, tx idle):
  - rx_done at edge N → byte written at edge N
  - pop at edge N+1
  - cmd_* high in cycle N+1..N+2 (the DECODE cycle)
  - tx_start high in the cycle after DECODE
- Only one command is processed at a time. The FIFO continues to accept bytes while in START/WAIT.
- tx_start is never asserted while tx_busy=1, and never twice without an intervening tx_done.

Test Plan:
1. Reset, then rx_data=0x72 ('r') with rx_done → cmd_run single-cycle pulse 2 cycles after rx_done; tx_start once with tx_data=0x52; model tx_done → FSM returns to IDLE.
2. Bytes 'C','n','S' back-to-back while tx_busy=1 → FIFO holds 3; after tx_busy drops and each tx_done arrives, pulses cmd_clear, cmd_min, cmd_sec in order; tx_data sequence 0x43, 0x4E, 0x53.
3. Byte 0x7A ('z') → no cmd_* pulse; tx_data=0x3F. Byte 0x0D → no pulse, no tx_start.
4. With tx_busy held 1 and FSM in START, push 5 bytes with FIFO_DEPTH=4 → fifth byte raises overflow for 1 cycle; the four stored bytes are processed in order once tx_busy=0.
5. ECHO_EN=0: 'm','h' → cmd_mode then cmd_hour pulses, one DECODE per byte; tx_start never asserted.
6. Assert rst in WAIT with 2 bytes queued → tx_start/cmd_* immediately 0, FIFO empty, tx_data=0; a later 'r' is handled normally as in scenario 1.
